// File: rtl/multiexp_feeder.sv
// Captures NUM_IN {point, scalar} pairs, then replays the whole set NUM_ROUNDS
// times as a valid/ready beat stream, in the order the multiexp core consumes.
module multiexp_feeder #(
  parameter int PNT_BITS   = 768,
  parameter int SCL_BITS   = 256,
  parameter int NUM_IN     = 4,
  parameter int NUM_ROUNDS = 256,
  parameter int CTL_BITS   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [PNT_BITS+SCL_BITS-1:0] i_ld_dat,
  input  logic                         i_ld_val,
  output logic                         o_ld_rdy,
  output logic [PNT_BITS+SCL_BITS-1:0] o_dat,
  output logic                         o_val,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic [CTL_BITS-1:0]          o_ctl,
  input  logic                         i_rdy,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [1:0]                   o_state
);

  localparam int DW    = PNT_BITS + SCL_BITS;
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int RND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Handshakes: a load entry is taken when i_ld_val && o_ld_rdy, and an output
  // beat transfers when o_val && i_rdy; o_dat/o_ctl only change on a transfer.
  state_t             state_q;
  logic [IDX_W-1:0]   ld_idx_q;
  logic [IDX_W-1:0]   beat_idx_q;
  logic [RND_W-1:0]   rnd_q;
  logic [DW-1:0]      buf_q [NUM_IN];
  logic [DW-1:0]      dat_q;
  logic               val_q;
  logic               ld_rdy_q;
  logic               busy_q;
  logic               done_q;

  logic               ld_acc;
  logic               xfer;
  logic               ld_last;
  logic               beat_last;
  logic               rnd_last;
  logic [IDX_W-1:0]   beat_idx_d;
  logic [DW-1:0]      first_dat_d;

  assign ld_acc     = i_ld_val && ld_rdy_q;
  assign xfer       = val_q && i_rdy;
  assign ld_last    = (ld_idx_q == IDX_W'(NUM_IN - 1));
  assign beat_last  = (beat_idx_q == IDX_W'(NUM_IN - 1));
  assign rnd_last   = (rnd_q == RND_W'(NUM_ROUNDS - 1));
  assign beat_idx_d = beat_last ? '0 : beat_idx_q + IDX_W'(1);
  // With a single entry, beat 0 is the entry arriving in this very cycle.
  assign first_dat_d = (NUM_IN == 1) ? i_ld_dat : buf_q[0];

  always_ff @(posedge i_clk) begin
    if (ld_acc) begin
      buf_q[ld_idx_q] <= i_ld_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      ld_idx_q   <= '0;
      beat_idx_q <= '0;
      rnd_q      <= '0;
      dat_q      <= '0;
      val_q      <= 1'b0;
      ld_rdy_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          ld_rdy_q <= 1'b1;
          if (ld_acc) begin
            busy_q <= 1'b1;
            if (ld_last) begin
              state_q    <= ST_STREAM;
              ld_idx_q   <= '0;
              ld_rdy_q   <= 1'b0;
              val_q      <= 1'b1;
              dat_q      <= first_dat_d;
              beat_idx_q <= '0;
              rnd_q      <= '0;
            end else begin
              state_q  <= ST_LOAD;
              ld_idx_q <= ld_idx_q + IDX_W'(1);
            end
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            if (beat_last && rnd_last) begin
              state_q    <= ST_IDLE;
              val_q      <= 1'b0;
              dat_q      <= '0;
              beat_idx_q <= '0;
              rnd_q      <= '0;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              ld_rdy_q   <= 1'b1;
            end else begin
              beat_idx_q <= beat_idx_d;
              dat_q      <= buf_q[beat_idx_d];
              if (beat_last) begin
                rnd_q <= rnd_q + RND_W'(1);
              end
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          val_q    <= 1'b0;
          ld_rdy_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ld_rdy = ld_rdy_q;
  assign o_dat    = dat_q;
  assign o_val    = val_q;
  assign o_sop    = val_q;
  assign o_eop    = val_q;
  assign o_ctl    = CTL_BITS'(beat_idx_q);
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_multiexp_feeder.sv
// Directed bench for multiexp_feeder: a 4-entry/3-round instance and a
// 1-entry/2-round instance, checked against a queue of expected beats.
module tb_multiexp_feeder;

  localparam int PB = 24;
  localparam int SB = 8;
  localparam int DW = PB + SB;
  localparam int CB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [DW-1:0] a_ld_dat, a_dat;
  logic          a_ld_val, a_ld_rdy, a_val, a_sop, a_eop, a_rdy, a_busy, a_done;
  logic [CB-1:0] a_ctl;
  logic [1:0]    a_state;

  logic [DW-1:0] b_ld_dat, b_dat;
  logic          b_ld_val, b_ld_rdy, b_val, b_sop, b_eop, b_rdy, b_busy, b_done;
  logic [CB-1:0] b_ctl;
  logic [1:0]    b_state;

  multiexp_feeder #(
    .PNT_BITS(PB), .SCL_BITS(SB), .NUM_IN(4), .NUM_ROUNDS(3), .CTL_BITS(CB)
  ) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_ld_dat(a_ld_dat), .i_ld_val(a_ld_val),
    .o_ld_rdy(a_ld_rdy), .o_dat(a_dat), .o_val(a_val), .o_sop(a_sop),
    .o_eop(a_eop), .o_ctl(a_ctl), .i_rdy(a_rdy), .o_busy(a_busy),
    .o_done(a_done), .o_state(a_state)
  );

  multiexp_feeder #(
    .PNT_BITS(PB), .SCL_BITS(SB), .NUM_IN(1), .NUM_ROUNDS(2), .CTL_BITS(CB)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_ld_dat(b_ld_dat), .i_ld_val(b_ld_val),
    .o_ld_rdy(b_ld_rdy), .o_dat(b_dat), .o_val(b_val), .o_sop(b_sop),
    .o_eop(b_eop), .o_ctl(b_ctl), .i_rdy(b_rdy), .o_busy(b_busy),
    .o_done(b_done), .o_state(b_state)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] exp_q[$];
  logic [CB-1:0] exp_ctl_q[$];
  logic [DW-1:0] ld_vec [8];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [PB-1:0] p, input logic [SB-1:0] s);
    return {p, s};
  endfunction

  task automatic push_batch(input int n, input int rounds);
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(ld_vec[i]);
        exp_ctl_q.push_back(CB'(i));
      end
    end
  endtask

  // Starts at a negedge, returns at the negedge where the first beat must show.
  task automatic load_a(input int n);
    int k = 0;
    int guard = 0;
    logic rdy;
    while (k < n && guard < 50) begin
      if (k > 0) chk("ld_busy", a_busy, 1);
      rdy      = a_ld_rdy;
      a_ld_val = 1'b1;
      a_ld_dat = ld_vec[k];
      if (rdy) k++;
      @(negedge clk);
      guard++;
    end
    a_ld_val = 1'b0;
    a_ld_dat = '0;
    if (k < n) chk("ld_timeout", k, n);
    chk("first_beat_val", a_val, 1);
    chk("first_beat_ctl", a_ctl, 0);
    chk("ld_rdy_low", a_ld_rdy, 0);
  endtask

  task automatic stream_a(input int n, input bit rnd, input bit expect_end);
    int popped = 0;
    int guard = 0;
    bit r;
    while (popped < n && exp_q.size() > 0 && guard < 200) begin
      chk("s_val", a_val, 1);
      chk("s_dat", a_dat, exp_q[0]);
      chk("s_ctl", a_ctl, exp_ctl_q[0]);
      chk("s_sop_eop", {a_sop, a_eop}, 2'b11);
      chk("s_done", a_done, 0);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a_rdy = r;
      if (r) begin
        void'(exp_q.pop_front());
        void'(exp_ctl_q.pop_front());
        popped++;
      end
      @(negedge clk);
      guard++;
    end
    a_rdy = 1'b0;
    if (popped < n) chk("s_timeout", popped, n);
    if (expect_end) begin
      chk("end_val", a_val, 0);
      chk("end_done", a_done, 1);
      chk("end_ld_rdy", a_ld_rdy, 1);
      chk("end_busy", a_busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    a_ld_dat = '0; a_ld_val = 1'b0; a_rdy = 1'b0;
    b_ld_dat = '0; b_ld_val = 1'b0; b_rdy = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_val", a_val, 0);
    chk("rst_sop_eop", {a_sop, a_eop}, 0);
    chk("rst_ctl", a_ctl, 0);
    chk("rst_dat", a_dat, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ld_rdy", a_ld_rdy, 0);
    chk("rst_state", a_state, 0);
    chk("rst_b_val", b_val, 0);
    chk("rst_b_ld_rdy", b_ld_rdy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ld_rdy", a_ld_rdy, 1);
    chk("idle_busy", a_busy, 0);

    // Basic batch, ready held high
    for (int i = 0; i < 4; i++) ld_vec[i] = mk(24'hC00000 + PB'(i), SB'(8'h11 * (i + 1)));
    push_batch(4, 3);
    load_a(4);
    stream_a(12, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_pulse", a_done, 0);

    // Same batch, random backpressure
    push_batch(4, 3);
    load_a(4);
    stream_a(12, 1'b1, 1'b1);
    @(negedge clk);
    chk("done_pulse_rnd", a_done, 0);

    // Six offered entries, only four taken
    for (int i = 0; i < 6; i++) ld_vec[i] = mk(24'hD00000 + PB'(i), SB'(8'h51 + i));
    push_batch(4, 3);
    a_rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("ovf_ld_rdy", a_ld_rdy, (k < 4) ? 1 : 0);
      a_ld_val = 1'b1;
      a_ld_dat = ld_vec[k];
      @(negedge clk);
    end
    a_ld_val = 1'b0;
    stream_a(12, 1'b0, 1'b1);
    @(negedge clk);

    // Reset during round 1, beat 2
    for (int i = 0; i < 4; i++) ld_vec[i] = mk(24'hC00000 + PB'(i), SB'(8'h11 * (i + 1)));
    push_batch(4, 3);
    load_a(4);
    stream_a(6, 1'b0, 1'b0);
    chk("rst_pre_ctl", a_ctl, 2);
    chk("rst_pre_dat", a_dat, ld_vec[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("async_val", a_val, 0);
    chk("async_dat", a_dat, 0);
    chk("async_ctl", a_ctl, 0);
    chk("async_busy", a_busy, 0);
    chk("async_ld_rdy", a_ld_rdy, 0);
    chk("async_state", a_state, 0);
    exp_q.delete();
    exp_ctl_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) ld_vec[i] = mk(24'hE00000 + PB'(i), SB'(8'hA0 + i));
    push_batch(4, 3);
    load_a(4);
    stream_a(12, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_pulse_post_rst", a_done, 0);

    // Back-to-back: second load starts in the done cycle
    for (int i = 0; i < 4; i++) ld_vec[i] = mk(24'hF00000 + PB'(i), SB'(8'h61 + i));
    push_batch(4, 3);
    load_a(4);
    stream_a(12, 1'b1, 1'b1);
    chk("b2b_ld_rdy", a_ld_rdy, 1);
    for (int i = 0; i < 4; i++) ld_vec[i] = mk(24'hB00000 + PB'(i), SB'(8'h71 + i));
    push_batch(4, 3);
    load_a(4);
    stream_a(12, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_pulse_b2b", a_done, 0);

    // Single-entry, two-round instance
    chk("b_ld_rdy_idle", b_ld_rdy, 1);
    b_ld_val = 1'b1;
    b_ld_dat = mk(24'h123456, 8'h9C);
    @(negedge clk);
    b_ld_val = 1'b0;
    b_ld_dat = '0;
    chk("b_first_val", b_val, 1);
    chk("b_first_ctl", b_ctl, 0);
    chk("b_first_dat", b_dat, mk(24'h123456, 8'h9C));
    chk("b_ld_rdy_low", b_ld_rdy, 0);
    chk("b_busy", b_busy, 1);
    b_rdy = 1'b1;
    @(negedge clk);
    chk("b_second_val", b_val, 1);
    chk("b_second_ctl", b_ctl, 0);
    chk("b_second_dat", b_dat, mk(24'h123456, 8'h9C));
    chk("b_second_done", b_done, 0);
    @(negedge clk);
    b_rdy = 1'b0;
    chk("b_end_val", b_val, 0);
    chk("b_end_done", b_done, 1);
    chk("b_end_ld_rdy", b_ld_rdy, 1);
    @(negedge clk);
    chk("b_done_pulse", b_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
